// File: rtl/i2c_regfile_target_pkg.sv
// Shared types and constants for the I2C register-file target.
package i2c_pkg;

    typedef enum logic [3:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        PTR,
        PTR_ACK,
        WDATA,
        WDATA_ACK,
        RDATA,
        RDATA_ACK
    } i2c_state_t;

    localparam logic ACK       = 1'b0;
    localparam logic NACK      = 1'b1;
    localparam int   BIT_CNT_W = 4;

endpackage

// File: rtl/i2c_regfile_target_if.sv
// I2C pin bundle: raw SCL/SDA from the board, open-drain SDA drive back out.
interface i2c_regfile_target_if;

    logic I_scl;
    logic I_sda;
    logic O_sda;
    logic OE_sda;

    modport master (output I_scl, output I_sda, input O_sda, input OE_sda);
    modport slave  (input I_scl, input I_sda, output O_sda, output OE_sda);

endinterface

// File: rtl/i2c_regfile_target_line_filter.sv
// Synchroniser plus glitch filter for one I2C line; emits one-clock rise/fall pulses.
module i2c_line_filter #(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 3
) (
    input  logic I_clk,
    input  logic I_rst,
    input  logic I_pin,
    output logic O_level,
    output logic O_rise,
    output logic O_fall
);

    localparam int CW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(FILT_LEN - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   level_q, level_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;
    logic                   synced;

    assign synced = sync_q[SYNC_STAGES-1];

    always_ff @(posedge I_clk or posedge I_rst) begin
        if (I_rst) begin
            sync_q  <= '1;
            cnt_q   <= CNT_LOAD;
            level_q <= 1'b1;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], I_pin};
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    // Down-counter reloads whenever the synced input agrees with the accepted level.
    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        if (synced == level_q) begin
            cnt_d = CNT_LOAD;
        end else if (cnt_q == '0) begin
            level_d = synced;
            rise_d  = synced;
            fall_d  = ~synced;
            cnt_d   = CNT_LOAD;
        end else begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    assign O_level = level_q;
    assign O_rise  = rise_q;
    assign O_fall  = fall_q;

endmodule

// File: rtl/i2c_regfile_target.sv
// Oversampled I2C target with a byte register file, auto-incrementing pointer and write strobe.
//  state     | meaning
//  IDLE      | not addressed, SDA released
//  ADDR      | shifting in 7-bit address + R/W
//  ADDR_ACK  | driving ACK for matched address
//  PTR       | shifting in register pointer
//  PTR_ACK   | driving ACK for valid pointer
//  WDATA     | shifting in write data byte
//  WDATA_ACK | driving ACK for committed byte
//  RDATA     | shifting out regs[ptr] MSB first
//  RDATA_ACK | sampling controller ACK/NACK
module i2c_regfile_target
    import i2c_pkg::*;
#(
    parameter int ADDR_W      = 7,
    parameter int NREGS       = 16,
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 3,
    parameter int AUTO_INC    = 1
) (
    input  logic                     I_clk,
    input  logic                     I_rst,
    i2c_regfile_target_if.slave      bus,
    input  logic [ADDR_W-1:0]        I_myaddr,
    output logic [NREGS*8-1:0]       O_regs,
    output logic                     O_wr_stb,
    output logic [$clog2(NREGS)-1:0] O_wr_idx,
    output logic                     O_busy
);

    localparam int PW = $clog2(NREGS);

    logic scl_f, scl_rise, scl_fall;
    logic sda_f, sda_rise, sda_fall;
    logic start, stop;

    i2c_line_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN)) u_scl_filt (
        .I_clk  (I_clk),
        .I_rst  (I_rst),
        .I_pin  (bus.I_scl),
        .O_level(scl_f),
        .O_rise (scl_rise),
        .O_fall (scl_fall)
    );

    i2c_line_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN)) u_sda_filt (
        .I_clk  (I_clk),
        .I_rst  (I_rst),
        .I_pin  (bus.I_sda),
        .O_level(sda_f),
        .O_rise (sda_rise),
        .O_fall (sda_fall)
    );

    assign start = sda_fall & scl_f;
    assign stop  = sda_rise & scl_f;

    i2c_state_t                 state_q, state_d;
    logic [BIT_CNT_W-1:0]       bits_q, bits_d;
    logic [7:0]                 shift_q, shift_d;
    logic [PW-1:0]              ptr_q, ptr_d;
    logic [NREGS-1:0][7:0]      regs_q, regs_d;
    logic                       oe_q, oe_d;
    logic                       busy_q, busy_d;
    logic                       rw_q, rw_d;
    logic                       ack_q, ack_d;
    logic [ADDR_W-1:0]          myaddr_q, myaddr_d;
    logic                       wr_stb_q, wr_stb_d;
    logic [PW-1:0]              wr_idx_q, wr_idx_d;
    logic [7:0]                 rx_byte;
    logic [PW-1:0]              ptr_inc;

    assign rx_byte = {shift_q[6:0], sda_f};
    assign ptr_inc = ptr_q + PW'(AUTO_INC);

    always_ff @(posedge I_clk or posedge I_rst) begin
        if (I_rst) begin
            state_q  <= IDLE;
            bits_q   <= '0;
            shift_q  <= '0;
            ptr_q    <= '0;
            regs_q   <= '0;
            oe_q     <= 1'b0;
            busy_q   <= 1'b0;
            rw_q     <= 1'b0;
            ack_q    <= NACK;
            myaddr_q <= '0;
            wr_stb_q <= 1'b0;
            wr_idx_q <= '0;
        end else begin
            state_q  <= state_d;
            bits_q   <= bits_d;
            shift_q  <= shift_d;
            ptr_q    <= ptr_d;
            regs_q   <= regs_d;
            oe_q     <= oe_d;
            busy_q   <= busy_d;
            rw_q     <= rw_d;
            ack_q    <= ack_d;
            myaddr_q <= myaddr_d;
            wr_stb_q <= wr_stb_d;
            wr_idx_q <= wr_idx_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        bits_d   = bits_q;
        shift_d  = shift_q;
        ptr_d    = ptr_q;
        regs_d   = regs_q;
        oe_d     = oe_q;
        busy_d   = busy_q;
        rw_d     = rw_q;
        ack_d    = ack_q;
        myaddr_d = myaddr_q;
        wr_stb_d = 1'b0;
        wr_idx_d = wr_idx_q;

        if (start) begin
            state_d  = ADDR;
            bits_d   = BIT_CNT_W'(8);
            oe_d     = 1'b0;
            myaddr_d = I_myaddr;
        end else if (stop) begin
            state_d = IDLE;
            oe_d    = 1'b0;
            busy_d  = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: ;
                ADDR, PTR, WDATA: begin
                    // Bytes complete on the 8th rise; ACK decisions wait for the following fall.
                    if (scl_rise && bits_q != '0) begin
                        shift_d = rx_byte;
                        bits_d  = bits_q - BIT_CNT_W'(1);
                        if (state_q == WDATA && bits_q == BIT_CNT_W'(1)) begin
                            regs_d[ptr_q] = rx_byte;
                            wr_stb_d      = 1'b1;
                            wr_idx_d      = ptr_q;
                            ptr_d         = ptr_inc;
                        end
                    end else if (scl_fall && bits_q == '0) begin
                        if (state_q == ADDR) begin
                            if (shift_q[7:1] == myaddr_q) begin
                                state_d = ADDR_ACK;
                                oe_d    = 1'b1;
                                busy_d  = 1'b1;
                                rw_d    = shift_q[0];
                            end else begin
                                state_d = IDLE;
                                busy_d  = 1'b0;
                            end
                        end else if (state_q == PTR) begin
                            if ({1'b0, shift_q} < 9'(NREGS)) begin
                                ptr_d   = shift_q[PW-1:0];
                                state_d = PTR_ACK;
                                oe_d    = 1'b1;
                            end else begin
                                state_d = IDLE;
                                busy_d  = 1'b0;
                            end
                        end else begin
                            state_d = WDATA_ACK;
                            oe_d    = 1'b1;
                        end
                    end
                end
                ADDR_ACK: begin
                    if (scl_fall) begin
                        bits_d = BIT_CNT_W'(8);
                        if (rw_q) begin
                            state_d = RDATA;
                            shift_d = regs_q[ptr_q];
                            oe_d    = ~regs_q[ptr_q][7];
                        end else begin
                            state_d = PTR;
                            oe_d    = 1'b0;
                        end
                    end
                end
                PTR_ACK, WDATA_ACK: begin
                    if (scl_fall) begin
                        state_d = WDATA;
                        bits_d  = BIT_CNT_W'(8);
                        oe_d    = 1'b0;
                    end
                end
                RDATA: begin
                    if (scl_rise && bits_q != '0) begin
                        bits_d = bits_q - BIT_CNT_W'(1);
                    end else if (scl_fall && bits_q == '0) begin
                        state_d = RDATA_ACK;
                        oe_d    = 1'b0;
                    end else if (scl_fall && bits_q != BIT_CNT_W'(8)) begin
                        shift_d = {shift_q[6:0], 1'b0};
                        oe_d    = ~shift_q[6];
                    end
                end
                RDATA_ACK: begin
                    if (scl_rise) begin
                        ack_d = sda_f;
                    end else if (scl_fall) begin
                        ptr_d = ptr_inc;
                        if (ack_q == ACK) begin
                            state_d = RDATA;
                            bits_d  = BIT_CNT_W'(8);
                            shift_d = regs_q[ptr_inc];
                            oe_d    = ~regs_q[ptr_inc][7];
                        end else begin
                            state_d = IDLE;
                            busy_d  = 1'b0;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign bus.O_sda  = 1'b0;
    assign bus.OE_sda = oe_q;
    assign O_regs     = regs_q;
    assign O_wr_stb   = wr_stb_q;
    assign O_wr_idx   = wr_idx_q;
    assign O_busy     = busy_q;

endmodule

// File: tb/tb_i2c_regfile_target.sv
// Directed bench: bit-banged I2C controller against the register-file target (NREGS=16, address 0x14).
module tb_i2c_regfile_target;

    localparam int Q = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         scl_m = 1'b1;
    logic         sda_m = 1'b1;
    logic [6:0]   myaddr = 7'h14;
    logic [127:0] regs;
    logic         wr_stb;
    logic [3:0]   wr_idx;
    logic         busy;

    int n_assert = 0;
    int n_fail   = 0;

    int         stb_total = 0;
    logic [3:0] stb_log [0:63];
    int         oe_hi_total = 0;

    i2c_regfile_target_if bus ();

    assign bus.I_scl = scl_m;
    assign bus.I_sda = sda_m & ~bus.OE_sda;

    always #5 clk = ~clk;

    i2c_regfile_target #(
        .ADDR_W(7), .NREGS(16), .SYNC_STAGES(2), .FILT_LEN(3), .AUTO_INC(1)
    ) dut (
        .I_clk   (clk),
        .I_rst   (rst),
        .bus     (bus),
        .I_myaddr(myaddr),
        .O_regs  (regs),
        .O_wr_stb(wr_stb),
        .O_wr_idx(wr_idx),
        .O_busy  (busy)
    );

    always @(posedge clk) begin
        if (wr_stb) begin
            stb_log[stb_total[5:0]] <= wr_idx;
            stb_total <= stb_total + 1;
        end
    end

    always @(negedge clk) begin
        if (bus.OE_sda) oe_hi_total <= oe_hi_total + 1;
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick_q();
        repeat (Q) @(posedge clk);
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; tick_q();
        scl_m = 1'b1; tick_q();
        sda_m = 1'b0; tick_q();
        scl_m = 1'b0; tick_q();
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; tick_q();
        scl_m = 1'b1; tick_q();
        sda_m = 1'b1; tick_q();
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        for (int i = 7; i >= 0; i--) begin
            sda_m = b[i]; tick_q();
            scl_m = 1'b1; tick_q(); tick_q();
            scl_m = 1'b0; tick_q();
        end
        sda_m = 1'b1; tick_q();
        scl_m = 1'b1; tick_q();
        @(negedge clk);
        ack = bus.I_sda;
        tick_q();
        scl_m = 1'b0; tick_q();
    endtask

    task automatic read_byte(input logic mack, output logic [7:0] b);
        for (int i = 7; i >= 0; i--) begin
            sda_m = 1'b1; tick_q();
            scl_m = 1'b1; tick_q();
            @(negedge clk);
            b[i] = bus.I_sda;
            tick_q();
            scl_m = 1'b0; tick_q();
        end
        sda_m = mack; tick_q();
        scl_m = 1'b1; tick_q(); tick_q();
        scl_m = 1'b0; tick_q();
    endtask

    initial begin
        logic       ack;
        logic [7:0] rd;
        logic       b7;
        int         s0;
        int         oe0;

        repeat (4) @(posedge clk);
        @(negedge clk);
        check("rst_oe",     128'(bus.OE_sda), 128'(1'b0));
        check("rst_osda",   128'(bus.O_sda),  128'(1'b0));
        check("rst_regs",   regs,             128'h0);
        check("rst_stb",    128'(wr_stb),     128'(1'b0));
        check("rst_idx",    128'(wr_idx),     128'(4'd0));
        check("rst_busy",   128'(busy),       128'(1'b0));
        rst = 1'b0;
        tick_q();

        // Single write: regs[0] = 0xF0
        s0 = stb_total;
        i2c_start();
        write_byte(8'h28, ack); check("t1_addr_ack", 128'(ack), 128'(1'b0));
        check("t1_busy", 128'(busy), 128'(1'b1));
        write_byte(8'h00, ack); check("t1_ptr_ack",  128'(ack), 128'(1'b0));
        write_byte(8'hF0, ack); check("t1_data_ack", 128'(ack), 128'(1'b0));
        i2c_stop();
        tick_q();
        check("t1_regs",     regs, 128'h0000_0000_0000_0000_0000_0000_0000_00F0);
        check("t1_stb_cnt",  128'(stb_total - s0), 128'(1));
        check("t1_stb_idx",  128'(stb_log[s0[5:0]]), 128'(4'd0));
        check("t1_busy_end", 128'(busy), 128'(1'b0));

        // Pointer set, repeated START, read one byte with NACK
        i2c_start();
        write_byte(8'h28, ack); check("t2_addr_ack", 128'(ack), 128'(1'b0));
        write_byte(8'h00, ack); check("t2_ptr_ack",  128'(ack), 128'(1'b0));
        i2c_start();
        write_byte(8'h29, ack); check("t2_raddr_ack", 128'(ack), 128'(1'b0));
        read_byte(1'b1, rd);
        check("t2_rdata", 128'(rd), 128'(8'hF0));
        check("t2_oe_after_nack", 128'(bus.OE_sda), 128'(1'b0));
        check("t2_busy_after_nack", 128'(busy), 128'(1'b0));
        i2c_stop();
        tick_q();

        // Burst write across the wrap point
        s0 = stb_total;
        i2c_start();
        write_byte(8'h28, ack); check("t3_addr_ack", 128'(ack), 128'(1'b0));
        write_byte(8'h0E, ack); check("t3_ptr_ack",  128'(ack), 128'(1'b0));
        write_byte(8'hA1, ack); check("t3_d0_ack",   128'(ack), 128'(1'b0));
        write_byte(8'hB2, ack); check("t3_d1_ack",   128'(ack), 128'(1'b0));
        write_byte(8'hC3, ack); check("t3_d2_ack",   128'(ack), 128'(1'b0));
        i2c_stop();
        tick_q();
        check("t3_regs", regs, 128'hB2A1_0000_0000_0000_0000_0000_0000_00C3);
        check("t3_stb_cnt",  128'(stb_total - s0), 128'(3));
        check("t3_stb_idx0", 128'(stb_log[s0[5:0]]),        128'(4'd14));
        check("t3_stb_idx1", 128'(stb_log[6'(s0 + 1)]),     128'(4'd15));
        check("t3_stb_idx2", 128'(stb_log[6'(s0 + 2)]),     128'(4'd0));

        // Wrong address 0x15
        oe0 = oe_hi_total;
        i2c_start();
        write_byte(8'h2A, ack); check("t4_addr_nack", 128'(ack), 128'(1'b1));
        check("t4_busy", 128'(busy), 128'(1'b0));
        i2c_stop();
        tick_q();
        check("t4_oe_never", 128'(oe_hi_total - oe0), 128'(0));
        check("t4_regs", regs, 128'hB2A1_0000_0000_0000_0000_0000_0000_00C3);

        // Out-of-range pointer, trailing data ignored
        s0 = stb_total;
        i2c_start();
        write_byte(8'h28, ack); check("t5_addr_ack", 128'(ack), 128'(1'b0));
        write_byte(8'h10, ack); check("t5_ptr_nack", 128'(ack), 128'(1'b1));
        check("t5_busy", 128'(busy), 128'(1'b0));
        write_byte(8'h55, ack); check("t5_data_nack", 128'(ack), 128'(1'b1));
        i2c_stop();
        tick_q();
        check("t5_stb_cnt", 128'(stb_total - s0), 128'(0));
        check("t5_regs", regs, 128'hB2A1_0000_0000_0000_0000_0000_0000_00C3);

        // Two-byte read wrapping 15 -> 0
        i2c_start();
        write_byte(8'h28, ack); check("t6_addr_ack", 128'(ack), 128'(1'b0));
        write_byte(8'h0F, ack); check("t6_ptr_ack",  128'(ack), 128'(1'b0));
        i2c_start();
        write_byte(8'h29, ack); check("t6_raddr_ack", 128'(ack), 128'(1'b0));
        read_byte(1'b0, rd); check("t6_rd0", 128'(rd), 128'(8'hB2));
        read_byte(1'b1, rd); check("t6_rd1", 128'(rd), 128'(8'hC3));
        check("t6_oe_after_nack", 128'(bus.OE_sda), 128'(1'b0));
        i2c_stop();
        tick_q();

        // Reset while driving a read 0 bit (regs[15]=0xB2, bit6=0)
        i2c_start();
        write_byte(8'h28, ack); check("t7_addr_ack", 128'(ack), 128'(1'b0));
        write_byte(8'h0F, ack); check("t7_ptr_ack",  128'(ack), 128'(1'b0));
        i2c_start();
        write_byte(8'h29, ack); check("t7_raddr_ack", 128'(ack), 128'(1'b0));
        sda_m = 1'b1; tick_q();
        scl_m = 1'b1; tick_q();
        @(negedge clk);
        b7 = bus.I_sda;
        tick_q();
        scl_m = 1'b0; tick_q();
        check("t7_bit7", 128'(b7), 128'(1'b1));
        @(negedge clk);
        check("t7_oe_before_rst", 128'(bus.OE_sda), 128'(1'b1));
        rst = 1'b1;
        #1;
        check("t7_oe_async", 128'(bus.OE_sda), 128'(1'b0));
        check("t7_regs_clr", regs, 128'h0);
        check("t7_busy_clr", 128'(busy), 128'(1'b0));
        repeat (3) @(negedge clk);
        rst = 1'b0;
        tick_q();

        s0 = stb_total;
        i2c_start();
        write_byte(8'h28, ack); check("t8_addr_ack", 128'(ack), 128'(1'b0));
        write_byte(8'h03, ack); check("t8_ptr_ack",  128'(ack), 128'(1'b0));
        write_byte(8'h5A, ack); check("t8_data_ack", 128'(ack), 128'(1'b0));
        i2c_stop();
        tick_q();
        check("t8_regs", regs, 128'h0000_0000_0000_0000_0000_0000_5A00_0000);
        check("t8_stb_cnt", 128'(stb_total - s0), 128'(1));
        check("t8_stb_idx", 128'(stb_log[s0[5:0]]), 128'(4'd3));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
